data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter DW, default 32: data word width; SHALL be a multiple of 8.
REQ-002 Parameter AW, default 32: byte address width.
REQ-003 Parameter SETS, default 16: number of one-word lines; SHALL be a power of two ≥2; IW = log2(SETS), OW = log2(DW/8).
REQ-004 Parameter CW, default 16: statistics counter width.
REQ-005 Ports, one per line:
 clk  in  1  clock; all state updates on rising edge
 rst  in  1  reset; synchronous, active-high
 req_i  in  1  CPU access valid
 we_i  in  1  1=store, 0=load
 byte_i  in  1  1=byte access, 0=word access
 addr_i  in  AW  byte address
 wdata_i  in  DW  store data (byte access uses bits [7:0])
 flush_i  in  1  invalidate all lines
 rdata_o  out  DW  load data
 stall_o  out  1  CPU SHALL hold all request inputs stable while 1
 mem_req_o  out  1  backing-memory request
 mem_we_o  out  1  backing-memory write
 mem_addr_o  out  AW  word-aligned address (low OW bits zero)
 mem_wdata_o  out  DW  write data
 mem_be_o  out  DW/8  byte-lane enables
 mem_rdata_i  in  DW  read data, valid with ack
 mem_ack_i  in  1  single-cycle completion
 hit_cnt_o  out  CW  load hits
 miss_cnt_o  out  CW  load misses

Function
REQ-006 Address split: index = addr_i[OW+IW-1:OW], tag = addr_i[AW-1:OW+IW]; hit = valid[index] and stored tag equals tag.
REQ-007 Policy: direct-mapped, write-through, no-write-allocate; one word per line.
REQ-008 FSM states IDLE, FILL, WRITE; transitions only on clk edge.
REQ-009 IDLE: load hit -> stall_o=0 combinationally, rdata_o valid same cycle, stay IDLE (zero-wait).
REQ-010 IDLE: load miss -> stall_o=1 same cycle, next state FILL, miss_cnt_o increments.
REQ-011 IDLE: store -> stall_o=1 same cycle, next state WRITE.
REQ-012 FILL: mem_req_o=1, mem_we_o=0, mem_be_o all ones, stall_o=1; on mem_ack_i write mem_rdata_i, tag, valid=1 to line, go IDLE; following cycle is a hit.
REQ-013 WRITE: mem_req_o=1, mem_we_o=1; stall_o=0 only in the mem_ack_i cycle; on ack, if line hit, merge enabled bytes into line; go IDLE.
REQ-014 Word access: mem_be_o all ones, mem_wdata_o = wdata_i. Byte access: mem_be_o one-hot at addr_i[OW-1:0], wdata_i[7:0] replicated to every lane.
REQ-015 Byte load: rdata_o = selected byte zero-extended to DW; word load: full line.
REQ-016 mem_req_o SHALL stay asserted, and mem address/data/be stable, from state entry until mem_ack_i; mem_ack_i in IDLE SHALL be ignored.
REQ-017 hit_cnt_o increments on an IDLE load hit unless the previous state was FILL (no double count after a fill).
REQ-018 Both counters SHALL saturate at 2^CW-1, never wrap.
REQ-019 flush_i: clears all valid bits at the edge; takes priority over a fill completing in the same cycle (line left invalid); FSM state unaffected.
REQ-020 Outside FILL/WRITE: mem_req_o=0, mem_we_o=0; req_i=0 in IDLE -> stall_o=0.

Reset
REQ-021 rst SHALL force IDLE, clear all valid bits, zero both counters, and drive mem_req_o=0, mem_we_o=0, stall_o=0 from the next cycle.
REQ-022 rst during FILL/WRITE SHALL abandon the transaction; no line update; a concurrent mem_ack_i is ignored.
REQ-023 Tag and data arrays need no reset.

Verification
REQ-024 After reset, word load 0x40 with mem_rdata_i=0xDEADBEEF acked 3 cycles later -> stall_o high 4 cycles, miss_cnt_o=1; repeat load -> zero-wait, rdata_o=0xDEADBEEF, hit_cnt_o=1.
REQ-025 Byte store 0xAB to 0x42 over cached line -> mem_be_o=0100, mem_wdata_o=0xABABABAB; then byte load 0x42 hits, rdata_o=0x000000AB.
REQ-026 Store to uncached 0x80 -> memory written, line not allocated; subsequent load 0x80 misses.
REQ-027 Loads to 0x40 then 0x40+4*SETS (same index) -> both miss, second evicts first; reload 0x40 misses.
REQ-028 flush_i asserted in fill-ack cycle -> line invalid, next lookup misses; rst mid-FILL -> mem_req_o=0 next cycle, counters 0.
REQ-029 Force 2^CW+5 load hits -> hit_cnt_o holds at 2^CW-1.

Source files
------------

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Loads that hit complete with zero wait; misses and all stores go to backing memory.
module data_cache #(
   parameter int DW   = 32,
   parameter int AW   = 32,
   parameter int SETS = 16,
   parameter int CW   = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_i,
   input  logic            we_i,
   input  logic            byte_i,
   input  logic [AW-1:0]   addr_i,
   input  logic [DW-1:0]   wdata_i,
   input  logic            flush_i,
   output logic [DW-1:0]   rdata_o,
   output logic            stall_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [AW-1:0]   mem_addr_o,
   output logic [DW-1:0]   mem_wdata_o,
   output logic [DW/8-1:0] mem_be_o,
   input  logic [DW-1:0]   mem_rdata_i,
   input  logic            mem_ack_i,
   output logic [CW-1:0]   hit_cnt_o,
   output logic [CW-1:0]   miss_cnt_o
);

   localparam int NB = DW / 8;
   localparam int IW = $clog2(SETS);
   localparam int OW = $clog2(NB);
   localparam int TW = AW - OW - IW;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2
   } state_e;

   state_e          state_q;
   logic            prev_fill_q;
   logic [SETS-1:0] valid_q;
   logic [TW-1:0]   tag_q  [SETS];
   logic [DW-1:0]   data_q [SETS];
   logic [CW-1:0]   hit_cnt_q;
   logic [CW-1:0]   miss_cnt_q;
   logic [AW-1:0]   mem_addr_q;
   logic [DW-1:0]   mem_wdata_q;
   logic [NB-1:0]   mem_be_q;

   // CPU-side lookup, decoded straight from the request address
   logic [IW-1:0] req_idx;
   logic [TW-1:0] req_tag;
   logic [OW-1:0] req_off;
   logic          req_hit;
   logic [DW-1:0] req_line;
   logic [7:0]    req_byte;
   logic [NB-1:0] req_be;
   logic [DW-1:0] req_wdata;

   assign req_idx   = addr_i[OW+IW-1:OW];
   assign req_tag   = addr_i[AW-1:OW+IW];
   assign req_off   = addr_i[OW-1:0];
   assign req_hit   = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign req_line  = data_q[req_idx];
   assign req_byte  = req_line[{req_off, 3'b000} +: 8];
   assign req_be    = byte_i ? (NB'(1) << req_off) : {NB{1'b1}};
   assign req_wdata = byte_i ? {NB{wdata_i[7:0]}} : wdata_i;
   assign rdata_o   = byte_i ? DW'(req_byte) : req_line;

   // Memory-side line addressing uses the captured transaction address
   logic [IW-1:0] line_idx;
   logic [TW-1:0] line_tag;
   logic          line_hit;

   assign line_idx = mem_addr_q[OW+IW-1:OW];
   assign line_tag = mem_addr_q[AW-1:OW+IW];
   assign line_hit = valid_q[line_idx] && (tag_q[line_idx] == line_tag);

   assign mem_req_o   = (state_q != IDLE);
   assign mem_we_o    = (state_q == WRITE);
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_be_o    = mem_be_q;
   assign hit_cnt_o   = hit_cnt_q;
   assign miss_cnt_o  = miss_cnt_q;

   always_comb begin
      // NOTE: default first so every path assigns stall_o and no latch is inferred.
      stall_o = 1'b0;
      unique case (state_q)
         IDLE:    stall_o = req_i && (we_i || !req_hit);
         FILL:    stall_o = 1'b1;
         WRITE:   stall_o = !mem_ack_i;
         default: stall_o = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      if (rst) begin
         state_q     <= IDLE;
         prev_fill_q <= 1'b0;
         valid_q     <= '0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
      end else begin
         prev_fill_q <= (state_q == FILL);
         unique case (state_q)
            IDLE: begin
               if (req_i) begin
                  mem_addr_q  <= {addr_i[AW-1:OW], {OW{1'b0}}};
                  mem_wdata_q <= req_wdata;
                  mem_be_q    <= we_i ? req_be : {NB{1'b1}};
                  if (we_i) begin
                     state_q <= WRITE;
                  end else if (!req_hit) begin
                     state_q <= FILL;
                     if (miss_cnt_q != {CW{1'b1}}) miss_cnt_q <= miss_cnt_q + CW'(1);
                  end else if (!prev_fill_q) begin
                     // the hit right after a fill is the retried miss, already counted
                     if (hit_cnt_q != {CW{1'b1}}) hit_cnt_q <= hit_cnt_q + CW'(1);
                  end
               end
            end
            FILL: begin
               if (mem_ack_i) begin
                  valid_q[line_idx] <= 1'b1;
                  state_q           <= IDLE;
               end
            end
            WRITE: begin
               if (mem_ack_i) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
         if (flush_i) valid_q <= '0;
      end
   end

   // NOTE: tag and data arrays carry no reset; valid_q alone decides whether a line is usable.
   always_ff @(posedge clk) begin
      if (!rst && mem_ack_i) begin
         if (state_q == FILL) begin
            tag_q[line_idx]  <= line_tag;
            data_q[line_idx] <= mem_rdata_i;
         end else if (state_q == WRITE && line_hit) begin
            for (int b = 0; b < NB; b++) begin
               if (mem_be_q[b]) data_q[line_idx][8*b +: 8] <= mem_wdata_q[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: directed loads/stores against a latency-programmable memory model.
module tb_data_cache;

   localparam int CW   = 4;
   localparam int MAXC = (1 << CW) - 1;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } mem_exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_i, we_i, byte_i, flush_i;
   logic [31:0]   addr_i, wdata_i, rdata_o;
   logic          stall_o, mem_req_o, mem_we_o, mem_ack_i;
   logic [31:0]   mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic [3:0]    mem_be_o;
   logic [CW-1:0] hit_cnt_o, miss_cnt_o;

   int n_checks = 0;
   int n_errors = 0;
   int exp_hit  = 0;
   int exp_miss = 0;
   int mem_lat  = 1;
   bit flush_on_ack = 1'b0;
   bit idle_ack     = 1'b0;

   logic [31:0] load_q [$];
   mem_exp_t    mem_q  [$];
   logic [31:0] mem [logic [31:0]];

   data_cache #(.DW(32), .AW(32), .SETS(16), .CW(CW)) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .byte_i(byte_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .flush_i(flush_i), .rdata_o(rdata_o),
      .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
      .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
      .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
   endfunction

   // Backing memory: acks after mem_lat cycles of mem_req_o, optional flush or stray ack
   initial begin
      int cnt;
      logic [31:0] w;
      cnt = 0;
      mem_ack_i = 1'b0; mem_rdata_i = '0; flush_i = 1'b0;
      forever begin
         @(posedge clk); #1;
         mem_ack_i = 1'b0;
         flush_i   = 1'b0;
         if (mem_req_o) begin
            cnt++;
            if (cnt >= mem_lat) begin
               cnt = 0;
               mem_ack_i = 1'b1;
               if (mem_we_o) begin
                  w = mem_read(mem_addr_o);
                  for (int b = 0; b < 4; b++) if (mem_be_o[b]) w[8*b +: 8] = mem_wdata_o[8*b +: 8];
                  mem[mem_addr_o] = w;
               end else begin
                  mem_rdata_i = mem_read(mem_addr_o);
               end
               if (flush_on_ack) begin
                  flush_i = 1'b1;
                  flush_on_ack = 1'b0;
               end
            end
         end else begin
            cnt = 0;
            if (idle_ack) begin
               mem_ack_i = 1'b1;
               idle_ack  = 1'b0;
            end
         end
      end
   end

   // Load monitor: a load completes in any cycle it is presented without stall
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (!rst && req_i && !we_i && !stall_o) begin
            if (load_q.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL load_unexpected: got rdata 0x%0h, expected no load", rdata_o);
            end else begin
               e = load_q.pop_front();
               check("rdata", rdata_o, e);
            end
         end
      end
   end

   // Memory monitor: compares each acked transaction and its stability since the first cycle
   initial begin
      mem_exp_t    e;
      bit          in_txn;
      logic [36:0] snap;
      in_txn = 1'b0;
      snap   = '0;
      forever begin
         @(negedge clk);
         if (!mem_req_o) begin
            in_txn = 1'b0;
         end else begin
            if (!in_txn) begin
               snap   = {mem_we_o, mem_be_o, mem_addr_o};
               in_txn = 1'b1;
            end
            if (mem_ack_i) begin
               in_txn = 1'b0;
               check("mem_stable", {mem_we_o, mem_be_o, mem_addr_o}, snap);
               if (mem_q.size() == 0) begin
                  n_checks++; n_errors++;
                  $display("FAIL mem_unexpected: got addr 0x%0h we %0b, expected no access", mem_addr_o, mem_we_o);
               end else begin
                  e = mem_q.pop_front();
                  check("mem_we", mem_we_o, e.we);
                  check("mem_addr", mem_addr_o, e.addr);
                  check("mem_be", mem_be_o, e.be);
                  if (e.we) check("mem_wdata", mem_wdata_o, e.wdata);
               end
            end
         end
      end
   end

   task automatic do_load(input logic [31:0] addr, input logic byt, input logic [31:0] exp_data,
                          input int fills, input int lat);
      mem_exp_t e;
      int stalls;
      bit done;
      mem_lat = lat;
      load_q.push_back(exp_data);
      for (int i = 0; i < fills; i++) begin
         e.we = 1'b0; e.addr = addr & 32'hFFFF_FFFC; e.wdata = '0; e.be = 4'hF;
         mem_q.push_back(e);
      end
      @(posedge clk); #1;
      req_i = 1'b1; we_i = 1'b0; byte_i = byt; addr_i = addr; wdata_i = '0;
      stalls = 0; done = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!stall_o) begin done = 1'b1; break; end
         stalls++;
      end
      check("load_done", done, 1'b1);
      check("load_stall", stalls, fills * (lat + 1));
      @(posedge clk); #1;
      req_i = 1'b0;
      if (fills > 0) exp_miss = (exp_miss + fills > MAXC) ? MAXC : exp_miss + fills;
      else exp_hit = (exp_hit + 1 > MAXC) ? MAXC : exp_hit + 1;
   endtask

   task automatic do_store(input logic [31:0] addr, input logic byt, input logic [31:0] wdata,
                           input logic [31:0] exp_wdata, input logic [3:0] exp_be, input int lat);
      mem_exp_t e;
      int stalls;
      bit done;
      mem_lat = lat;
      e.we = 1'b1; e.addr = addr & 32'hFFFF_FFFC; e.wdata = exp_wdata; e.be = exp_be;
      mem_q.push_back(e);
      @(posedge clk); #1;
      req_i = 1'b1; we_i = 1'b1; byte_i = byt; addr_i = addr; wdata_i = wdata;
      stalls = 0; done = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!stall_o) begin done = 1'b1; break; end
         stalls++;
      end
      check("store_done", done, 1'b1);
      check("store_stall", stalls, lat);
      @(posedge clk); #1;
      req_i = 1'b0; we_i = 1'b0;
   endtask

   task automatic check_counters();
      @(negedge clk);
      check("hit_cnt", hit_cnt_o, exp_hit);
      check("miss_cnt", miss_cnt_o, exp_miss);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      mem_exp_t e;
      rst = 1'b1; req_i = 1'b0; we_i = 1'b0; byte_i = 1'b0; addr_i = '0; wdata_i = '0;
      mem[32'h40]  = 32'hDEAD_BEEF;
      mem[32'h104] = 32'hCAFE_F00D;
      mem[32'h200] = 32'h55AA_55AA;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_stall", stall_o, 1'b0);
      check("rst_mem_req", mem_req_o, 1'b0);
      check("rst_mem_we", mem_we_o, 1'b0);
      check("rst_hit_cnt", hit_cnt_o, 0);
      check("rst_miss_cnt", miss_cnt_o, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Miss with 3-cycle ack, then zero-wait hit
      do_load(32'h40, 1'b0, 32'hDEAD_BEEF, 1, 3);
      check_counters();
      do_load(32'h40, 1'b0, 32'hDEAD_BEEF, 0, 1);
      check_counters();

      // Byte store over cached line, then byte and word hits see merged data
      do_store(32'h42, 1'b1, 32'h0000_00AB, 32'hABAB_ABAB, 4'b0100, 2);
      do_load(32'h42, 1'b1, 32'h0000_00AB, 0, 1);
      do_load(32'h40, 1'b0, 32'hDEAB_BEEF, 0, 1);

      // Store to uncached 0x80 is not allocated; load then misses
      do_store(32'h80, 1'b0, 32'h1122_3344, 32'h1122_3344, 4'hF, 1);
      do_load(32'h80, 1'b0, 32'h1122_3344, 1, 2);
      do_load(32'h83, 1'b1, 32'h0000_0011, 0, 1);

      // 0x40 and 0x80 share index 0 and evict each other
      do_load(32'h40, 1'b0, 32'hDEAB_BEEF, 1, 1);
      do_load(32'h80, 1'b0, 32'h1122_3344, 1, 1);
      do_load(32'h40, 1'b0, 32'hDEAB_BEEF, 1, 2);
      check_counters();

      // Word store hit updates the line
      do_store(32'h40, 1'b0, 32'h1234_5678, 32'h1234_5678, 4'hF, 3);
      do_load(32'h40, 1'b0, 32'h1234_5678, 0, 1);
      do_load(32'h40, 1'b1, 32'h0000_0078, 0, 1);

      // Flush in the fill-ack cycle leaves the line invalid, so the held load refills
      flush_on_ack = 1'b1;
      do_load(32'h104, 1'b0, 32'hCAFE_F00D, 2, 2);
      do_load(32'h104, 1'b0, 32'hCAFE_F00D, 0, 1);
      check_counters();

      // A stray ack while idle is ignored
      idle_ack = 1'b1;
      repeat (2) @(posedge clk);
      do_load(32'h104, 1'b0, 32'hCAFE_F00D, 0, 1);
      check_counters();

      // Reset mid-fill, coinciding with the ack
      mem_lat = 2;
      e.we = 1'b0; e.addr = 32'h200; e.wdata = '0; e.be = 4'hF;
      mem_q.push_back(e);
      @(posedge clk); #1;
      req_i = 1'b1; we_i = 1'b0; byte_i = 1'b0; addr_i = 32'h200;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; req_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rstfill_mem_req", mem_req_o, 1'b0);
      check("rstfill_mem_we", mem_we_o, 1'b0);
      check("rstfill_stall", stall_o, 1'b0);
      check("rstfill_hit_cnt", hit_cnt_o, 0);
      check("rstfill_miss_cnt", miss_cnt_o, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_hit = 0; exp_miss = 0;
      do_load(32'h200, 1'b0, 32'h55AA_55AA, 1, 1);
      check_counters();

      // Hit counter saturates after 2^CW+5 hits
      for (int i = 0; i < MAXC + 6; i++) do_load(32'h200, 1'b0, 32'h55AA_55AA, 0, 1);
      @(negedge clk);
      check("hit_sat", hit_cnt_o, 15);

      // Miss counter saturates too (0x300/0x340 share index 0)
      for (int i = 0; i < 19; i++) begin
         if (i % 2 == 0) do_load(32'h300, 1'b0, 32'h5A5A_0300, 1, 1);
         else            do_load(32'h340, 1'b0, 32'h5A5A_0340, 1, 1);
      end
      @(negedge clk);
      check("miss_sat", miss_cnt_o, 15);
      check_counters();

      repeat (3) @(posedge clk);
      check("load_q_left", load_q.size(), 0);
      check("mem_q_left", mem_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
